// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - register-programmed buzzer burst sequencer with completion interrupt
module beep_sequencer #(
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned TICK_DIV   = 50000,
  parameter logic [15:0] DEF_HALF   = 16'd12500,
  parameter logic [15:0] DEF_ON     = 16'd100,
  parameter logic [15:0] DEF_OFF    = 16'd100,
  parameter logic [7:0]  DEF_REP    = 8'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t      state, state_d;
  logic        out_d;
  logic [15:0] half_period, on_time, off_time;
  logic [7:0]  repeat_reg;
  logic        irq_en, done;
  logic [7:0]  rep_left, rep_d;
  logic [15:0] w_on, won_d, w_off, woff_d;
  logic [15:0] hcnt, hcnt_d;
  logic [TW-1:0] tick_cnt, tick_d;
  logic [15:0] ticks_left, tleft_d;
  logic        done_set, done_clr;

  logic wr_en, ctrl_wr, start_req, stop_req, clr_req;
  logic [15:0] half_m1;
  logic        phase_end;

  // A zero duration or half-period behaves as one, so every reload is max(v,1)-1
  function automatic logic [15:0] m1(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == 2'd0);
  assign stop_req  = ctrl_wr && writedata[1];
  assign start_req = ctrl_wr && writedata[0] && !writedata[1];
  assign clr_req   = ctrl_wr && writedata[3];
  assign half_m1   = m1(half_period);
  assign phase_end = (tick_cnt == '0) && (ticks_left == 16'd0);
  assign irq       = done && irq_en;

  // Configuration registers, writable at any time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_period <= DEF_HALF;
      on_time     <= DEF_ON;
      off_time    <= DEF_OFF;
      repeat_reg  <= DEF_REP;
      irq_en      <= 1'b0;
    end else if (wr_en) begin
      case (address)
        2'd0: irq_en <= writedata[2];
        2'd1: half_period <= writedata[15:0];
        2'd2: begin
          on_time  <= writedata[15:0];
          off_time <= writedata[31:16];
        end
        default: repeat_reg <= writedata[7:0];
      endcase
    end
  end

  // DONE: a completing sequence beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 done <= 1'b0;
    else if (done_set)            done <= 1'b1;
    else if (clr_req || done_clr) done <= 1'b0;
  end

  // Sequencer state, working copies and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      out_port   <= IDLE_LEVEL;
      rep_left   <= 8'd0;
      w_on       <= 16'd0;
      w_off      <= 16'd0;
      hcnt       <= 16'd0;
      tick_cnt   <= '0;
      ticks_left <= 16'd0;
    end else begin
      state      <= state_d;
      out_port   <= out_d;
      rep_left   <= rep_d;
      w_on       <= won_d;
      w_off      <= woff_d;
      hcnt       <= hcnt_d;
      tick_cnt   <= tick_d;
      ticks_left <= tleft_d;
    end
  end

  // Next-state logic: burst/gap timing, tone toggling and repeat bookkeeping
  always_comb begin
    state_d  = state;
    out_d    = out_port;
    rep_d    = rep_left;
    won_d    = w_on;
    woff_d   = w_off;
    hcnt_d   = hcnt;
    tick_d   = tick_cnt;
    tleft_d  = ticks_left;
    done_set = 1'b0;
    done_clr = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_req) begin
          if (repeat_reg == 8'd0) begin
            done_set = 1'b1;
          end else begin
            state_d  = S_ON;
            out_d    = ~IDLE_LEVEL;
            hcnt_d   = half_m1;
            tick_d   = TICK_LAST;
            tleft_d  = m1(on_time);
            rep_d    = repeat_reg;
            won_d    = on_time;
            woff_d   = off_time;
            done_clr = 1'b1;
          end
        end
      end
      S_ON: begin
        if (hcnt == 16'd0) begin
          out_d  = ~out_port;
          hcnt_d = half_m1;
        end else begin
          hcnt_d = hcnt - 16'd1;
        end
        if (tick_cnt == '0) begin
          tick_d  = TICK_LAST;
          tleft_d = ticks_left - 16'd1;
        end else begin
          tick_d = tick_cnt - 1'b1;
        end
        if (phase_end) begin
          if (rep_left > 8'd1) begin
            rep_d  = rep_left - 8'd1;
            tick_d = TICK_LAST;
            if (w_off == 16'd0) begin
              out_d   = ~IDLE_LEVEL;
              hcnt_d  = half_m1;
              tleft_d = m1(w_on);
            end else begin
              state_d = S_OFF;
              out_d   = IDLE_LEVEL;
              tleft_d = w_off - 16'd1;
            end
          end else begin
            state_d  = S_IDLE;
            out_d    = IDLE_LEVEL;
            done_set = 1'b1;
          end
        end
      end
      S_OFF: begin
        out_d = IDLE_LEVEL;
        if (tick_cnt == '0) begin
          tick_d  = TICK_LAST;
          tleft_d = ticks_left - 16'd1;
        end else begin
          tick_d = tick_cnt - 1'b1;
        end
        if (phase_end) begin
          state_d = S_ON;
          out_d   = ~IDLE_LEVEL;
          hcnt_d  = half_m1;
          tick_d  = TICK_LAST;
          tleft_d = m1(w_on);
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = IDLE_LEVEL;
      end
    endcase

    if (stop_req) begin
      state_d  = S_IDLE;
      out_d    = IDLE_LEVEL;
      done_set = 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {29'd0, irq_en, done, (state != S_IDLE)};
      2'd1: readdata = {16'd0, half_period};
      2'd2: readdata = {off_time, on_time};
      default: readdata = {24'd0, repeat_reg};
    endcase
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// tb/tb_beep_sequencer.sv - directed self-checking bench for beep_sequencer
module tb_beep_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] v_out, v_busy, r;

  beep_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write is set up on the falling edge and accepted on the following rising edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = 2'd0;
  endtask

  // Samples out_port and BUSY once per cycle, first sample is the current cycle
  task automatic capture(input int n, output logic [31:0] vo, output logic [31:0] vb);
    vo = '0; vb = '0;
    for (int i = 0; i < n; i++) begin
      vo = {vo[30:0], out_port};
      vb = {vb[30:0], readdata[0]};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [15:0] half, input logic [15:0] on, input logic [15:0] off, input logic [7:0] rep);
    wr(2'd1, {16'd0, half});
    wr(2'd2, {off, on});
    wr(2'd3, {24'd0, rep});
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #12;
    check("rst_out", {31'd0, out_port}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, r); check("rst_ctrl", r, 32'd0);
    rd(2'd1, r); check("rst_half", r, 32'd12500);
    rd(2'd2, r); check("rst_onoff", r, 32'h0064_0064);
    rd(2'd3, r); check("rst_rep", r, 32'd1);
    @(negedge clk); reset_n = 1'b1;

    // Basic sequence with interrupt enabled
    cfg(16'd2, 16'd2, 16'd1, 8'd2);
    wr(2'd0, 32'h5);
    capture(20, v_out, v_busy);
    check("basic_out", v_out & 32'hFFFFF, 32'h33F33);
    check("basic_busy", v_busy & 32'hFFFFF, 32'hFFFFF);
    check("basic_end_out", {31'd0, out_port}, 32'd1);
    rd(2'd0, r); check("basic_end_ctrl", r, 32'h6);
    check("basic_irq", {31'd0, irq}, 32'd1);

    // Stop at T+5, then replay
    wr(2'd0, 32'h5);
    repeat (4) @(posedge clk);
    wr(2'd0, 32'h6);
    check("stop_out", {31'd0, out_port}, 32'd1);
    rd(2'd0, r); check("stop_ctrl", r, 32'h4);
    wr(2'd0, 32'h5);
    capture(20, v_out, v_busy);
    check("replay_out", v_out & 32'hFFFFF, 32'h33F33);
    check("replay_busy", v_busy & 32'hFFFFF, 32'hFFFFF);
    rd(2'd0, r); check("replay_ctrl", r, 32'h6);

    // REPEAT=0: DONE at once, never busy, irq masked
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h9);
    check("rep0_out", {31'd0, out_port}, 32'd1);
    rd(2'd0, r); check("rep0_ctrl", r, 32'h2);
    check("rep0_irq", {31'd0, irq}, 32'd0);
    capture(5, v_out, v_busy);
    check("rep0_quiet_out", v_out & 32'h1F, 32'h1F);
    check("rep0_quiet_busy", v_busy & 32'h1F, 32'h0);

    // HALF=0 and OFF=0: continuous toggling across both bursts
    cfg(16'd0, 16'd2, 16'd0, 8'd2);
    wr(2'd0, 32'h1);
    capture(16, v_out, v_busy);
    check("tog_out", v_out & 32'hFFFF, 32'h5555);
    check("tog_busy", v_busy & 32'hFFFF, 32'hFFFF);
    check("tog_end_out", {31'd0, out_port}, 32'd1);
    rd(2'd0, r); check("tog_end_ctrl", r, 32'h2);

    // START while busy does not disturb the sequence
    cfg(16'd2, 16'd2, 16'd1, 8'd2);
    wr(2'd0, 32'h1);
    fork
      capture(20, v_out, v_busy);
      begin repeat (3) @(posedge clk); wr(2'd0, 32'h1); end
    join
    check("busy_start_out", v_out & 32'hFFFFF, 32'h33F33);
    rd(2'd0, r); check("busy_start_ctrl", r, 32'h2);

    // START|STOP from idle stays idle, DONE untouched
    wr(2'd0, 32'h3);
    check("ss_out", {31'd0, out_port}, 32'd1);
    rd(2'd0, r); check("ss_ctrl", r, 32'h2);

    // CLR_DONE on the edge DONE sets: set wins
    cfg(16'd2, 16'd1, 16'd1, 8'd1);
    wr(2'd0, 32'h1);
    rd(2'd0, r); check("coll_started", r, 32'h1);
    repeat (3) @(posedge clk);
    wr(2'd0, 32'h8);
    rd(2'd0, r); check("coll_done", r, 32'h2);
    wr(2'd0, 32'h8);
    rd(2'd0, r); check("coll_cleared", r, 32'h0);

    // Asynchronous reset mid-burst
    cfg(16'd7, 16'd2, 16'd1, 8'd2);
    wr(2'd0, 32'h5);
    repeat (3) @(posedge clk);
    #2;
    check("mid_out_pre", {31'd0, out_port}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_out_rst", {31'd0, out_port}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1;
    rd(2'd0, r); check("post_ctrl", r, 32'd0);
    rd(2'd1, r); check("post_half", r, 32'd12500);
    rd(2'd2, r); check("post_onoff", r, 32'h0064_0064);
    rd(2'd3, r); check("post_rep", r, 32'd1);
    check("post_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/beep_sequencer.md
Name: beep_sequencer

Overview:
Avalon-MM slave controller that sequences the buzzer output on the system bus. Firmware programs tone pitch, on/off durations and repeat count, then writes START. The block generates N gated square-wave bursts on out_port with no further CPU involvement and raises an interrupt on completion. It occupies the PIO slot that currently drives the buzzer pin directly.

Parameters:
IDLE_LEVEL, 1, out_port level when silent; active burst starts at ~IDLE_LEVEL
TICK_DIV, 50000, clocks per duration tick (1 ms at 50 MHz)
DEF_HALF, 12500, reset value of HALF_PERIOD (2 kHz at 50 MHz)
DEF_ON, 100, reset value of ON_TIME (ticks)
DEF_OFF, 100, reset value of OFF_TIME (ticks)
DEF_REP, 1, reset value of REPEAT

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous assert, active-low
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read mux, zero-padded, no wait states
out_port  out  1  registered buzzer drive
irq  out  1  DONE & IRQ_EN

Behaviour:
- Write = chipselect && !write_n, sampled at posedge clk.
- Register map:
  - addr 0 CTRL. Write bits: b0 START, b1 STOP, b2 IRQ_EN (stored), b3 CLR_DONE. Read: {29'b0, IRQ_EN, DONE, BUSY}.
  - addr 1 HALF_PERIOD[15:0]. Read zero-extended.
  - addr 2 ON_TIME[15:0], OFF_TIME[31:16].
  - addr 3 REPEAT[7:0]. Read zero-extended.
- Reset values: state IDLE, out_port=IDLE_LEVEL, DONE=0, IRQ_EN=0, irq=0, BUSY=0, config registers = DEF_* parameters, all counters 0.
- FSM states:
  - IDLE:
    - START with REPEAT≠0 → ON on the accepting edge.
    - Working copies of ON_TIME, OFF_TIME and REPEAT are latched at that edge. DONE is cleared.
    - out_port = ~IDLE_LEVEL from that edge.
    - Half-period counter and tick counter are loaded.
    - START with REPEAT=0 sets DONE on the accepting edge; BUSY never asserts.
  - ON:
    - out_port toggles every max(HALF_PERIOD,1) clocks.
    - HALF_PERIOD is read live at each counter reload.
    - Phase length is exactly max(ON_TIME,1)*TICK_DIV clocks.
    - At phase end with remaining repeats > 1: go to OFF, or straight to ON if OFF_TIME=0. Decrement remaining repeats.
    - At phase end on the last repeat: go to IDLE, set DONE.
  - OFF:
    - out_port = IDLE_LEVEL for exactly OFF_TIME*TICK_DIV clocks, then → ON.
    - Re-entering ON restarts at ~IDLE_LEVEL.
- No trailing OFF gap after the final burst.
- BUSY = (state ≠ IDLE).
- START while BUSY: ignored. Config writes while BUSY: accepted; only HALF_PERIOD affects the running sequence.
- STOP from any state → IDLE on that edge, out_port=IDLE_LEVEL, DONE unchanged. STOP and START in the same write: STOP wins.
- CLR_DONE clears DONE. If DONE would set on the same edge, set wins.
- IRQ_EN bit is stored on every CTRL write.
- irq is combinational from registered DONE and IRQ_EN.
- Reset asserted mid-sequence: immediate return to reset values, out_port=IDLE_LEVEL asynchronously.

Test Plan:
1. Reset check: reset_n low → out_port=1, irq=0. Reads give addr0=0, addr1=12500, addr2=0x00640064, addr3=1.
2. Basic sequence. Config: TICK_DIV=4, HALF=2, ON=2, OFF=1, REP=2, START at edge T.
   - out_port over T..T+19: 0011 0011 1111 0011 0011, then 1.
   - BUSY=1 for 20 clocks; DONE=1 at T+20.
   - With IRQ_EN=1, irq=1 at T+20.
3. Stop and restart.
   - STOP written at T+5 of scenario 2 → out_port=1, BUSY=0 from T+6, DONE=0.
   - A subsequent START replays the full sequence.
4. Zero-value handling.
   - REPEAT=0 START → DONE=1 next cycle, out_port stays 1, BUSY never 1.
   - HALF=0 → out_port toggles every clock.
   - OFF=0, REP=2 → 16 consecutive toggling clocks.
5. Write collisions.
   - START during BUSY: sequence unaltered.
   - START|STOP in one write from IDLE: stays IDLE.
   - CLR_DONE on the DONE-setting edge: DONE=1.
6. Reset mid-burst: reset_n low at T+3 → out_port=1 immediately. After release, all registers are back to defaults.
